bmc_acs_scheduler: RTL
======================

// Module: bmc_acs_scheduler
// PURPOSE
//  Sequences the received symbol stream into the time-multiplexed BMC/ACS array of the Viterbi decoder.
//  Each accepted rx_pair is held and swept over all trellis state groups, one group per cycle.
//  Counts trellis stages per traceback block, flips the path-metric ping-pong bank once per stage,
//  and hands each finished block to the traceback unit through a req/ack handshake.
// PARAMETERS
//  NUM_STATES  64  trellis states (2^(K-1)), power of two
//  NUM_UNITS   8   parallel BMC/ACS units; GROUPS = NUM_STATES/NUM_UNITS, power of two, >=2
//  TB_LEN      32  trellis stages per traceback block, >=2
//  (derived) GW = $clog2(GROUPS), SW = $clog2(TB_LEN)
// PORTS
//  clk            in   1      system clock, all logic rising-edge
//  rst            in   1      synchronous reset, active-high
//  in_valid       in   1      rx_pair available
//  in_ready       out  1      scheduler accepts rx_pair this cycle
//  in_rx_pair     in   2      received hard-decision pair {bit1,bit0}
//  in_last        in   1      marks final symbol of frame (qualified by in_valid&in_ready)
//  bmc_en         out  1      BMC/ACS array computes group bmc_group this cycle
//  bmc_rx_pair    out  2      held rx_pair driven to all BMC units
//  bmc_group      out  GW     state group index
//  bmc_first      out  1      bmc_en & group==0 (ACS clears per-stage min tracker)
//  bmc_last       out  1      bmc_en & group==GROUPS-1 (ACS commits survivor word)
//  pm_bank        out  1      path-metric read bank; write bank is ~pm_bank
//  stage_cnt      out  SW     stage index within current block
//  tb_req         out  1      block complete, traceback requested
//  tb_depth       out  SW+1   stages in completed block (1..TB_LEN), valid with tb_req
//  tb_final       out  1      completed block ends the frame, valid with tb_req
//  tb_ack         in   1      traceback accepted request
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0 during rst, 1 first cycle after; bmc_en, bmc_first, bmc_last, tb_req,
//   tb_final=0; bmc_group, bmc_rx_pair, stage_cnt, pm_bank=0; tb_depth=0.
//  FSM states IDLE, RUN, TB_REQ.
//  IDLE: in_ready=1. Accept (in_valid&in_ready) -> latch pair and last flag, group=0, go RUN.
//  RUN: bmc_en=1 every cycle; group increments by 1 each cycle. Latency: accept in cycle t -> group 0 at t+1,
//   group GROUPS-1 at t+GROUPS. Throughput: 1 symbol per GROUPS cycles, no bubbles when fed.
//  Stage end (cycle with bmc_last=1): pm_bank toggles and stage_cnt advances on that edge.
//   - if stage_cnt==TB_LEN-1 or latched last: go TB_REQ; tb_depth=stage_cnt+1; tb_final=latched last;
//     stage_cnt wraps to 0; in_ready=0 in this cycle.
//   - else in_ready=1 in this cycle only; accept -> next cycle RUN group 0 with new pair (back-to-back);
//     no accept -> IDLE.
//  in_ready=0 in all other RUN cycles and in TB_REQ; in_rx_pair/in_last ignored when not accepted.
//  TB_REQ: tb_req=1, tb_depth/tb_final stable until cycle where tb_ack=1; next cycle tb_req=0, -> IDLE.
//   tb_ack while tb_req=0 ignored. tb_ack same cycle as entry is impossible (entry is registered).
//  tb_final block: also resets pm_bank to 0 on leaving TB_REQ (new frame starts on bank 0).
//  Non-final block: pm_bank continues toggling across block boundary (metrics carry over).
//  in_last on a symbol that is also stage TB_LEN-1: single TB_REQ, tb_depth=TB_LEN, tb_final=1.
//  rst mid-operation: abandon sweep/handshake immediately, all outputs to reset values next cycle.
//  All outputs registered; no combinational in->out path except in_ready is a registered state decode.
// STRUCTURE
//  Shared package viterbi_pkg: NUM_STATES, NUM_UNITS, TB_LEN defaults, GROUPS/GW/SW derivations,
//   scheduler state enum (IDLE/RUN/TB_REQ) for use by traceback and testbench.
//  Single module; group counter, stage counter and FSM kept flat. No sub-module.
// TESTING
//  Single symbol 2'b10 with in_last, tb_ack tied 1 -> bmc_en 8 cycles groups 0..7, bmc_rx_pair=2'b10,
//   tb_req 1 cycle with tb_depth=1, tb_final=1, pm_bank back to 0.
//  32 symbols back-to-back, in_valid held 1, tb_ack delayed 5 cycles -> 256 contiguous bmc_en cycles,
//   pm_bank toggles every 8 cycles, tb_req held 5 cycles with tb_depth=32, tb_final=0, in_ready=0 meanwhile.
//  Frame of 40 symbols (last on #40) -> two requests: tb_depth=32/tb_final=0 then tb_depth=8/tb_final=1.
//  Gapped input (in_valid 1 every 20 cycles) -> IDLE between symbols, stage_cnt increments by 1 per symbol,
//   bmc_first/bmc_last exactly once per symbol.
//  rst asserted at group 3 of stage 10 -> next cycle bmc_en=0, stage_cnt=0, pm_bank=0, in_ready=1 after rst drops.
//  Spurious tb_ack pulses in RUN/IDLE -> no state or output change.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder parameters and the scheduler state type, also used by traceback and benches.
package viterbi_pkg;

  localparam int NUM_STATES = 64;
  localparam int NUM_UNITS  = 8;
  localparam int TB_LEN     = 32;
  localparam int GROUPS     = NUM_STATES / NUM_UNITS;
  localparam int GW         = $clog2(GROUPS);
  localparam int SW         = $clog2(TB_LEN);

  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_RUN    = 2'd1,
    SCHED_TB_REQ = 2'd2
  } sched_state_t;

endpackage

// File: rtl/bmc_acs_scheduler.sv
// Feeds each accepted rx_pair across all state groups of the BMC/ACS array, counts stages per
// traceback block, flips the path-metric bank per stage and hands finished blocks to traceback.
//
// state        | meaning
// SCHED_IDLE   | waiting for a symbol, in_ready=1
// SCHED_RUN    | sweeping held pair over groups 0..GROUPS-1
// SCHED_TB_REQ | block complete, holding tb_req until tb_ack
module bmc_acs_scheduler
  import viterbi_pkg::*;
#(
  parameter int NUM_STATES = viterbi_pkg::NUM_STATES,
  parameter int NUM_UNITS  = viterbi_pkg::NUM_UNITS,
  parameter int TB_LEN     = viterbi_pkg::TB_LEN,
  localparam int GROUPS    = NUM_STATES / NUM_UNITS,
  localparam int GW        = $clog2(GROUPS),
  localparam int SW        = $clog2(TB_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_rx_pair,
  input  logic          in_last,
  output logic          bmc_en,
  output logic [1:0]    bmc_rx_pair,
  output logic [GW-1:0] bmc_group,
  output logic          bmc_first,
  output logic          bmc_last,
  output logic          pm_bank,
  output logic [SW-1:0] stage_cnt,
  output logic          tb_req,
  output logic [SW:0]   tb_depth,
  output logic          tb_final,
  input  logic          tb_ack
);

  sched_state_t  state_q, state_d;
  logic [GW-1:0] group_q;
  logic [SW-1:0] stage_q;
  logic          bank_q;
  logic [1:0]    pair_q;
  logic          last_q;
  logic [SW:0]   depth_q;
  logic          final_q;

  logic grp_end;
  logic blk_end;
  logic accept;

  assign grp_end = (group_q == GW'(GROUPS - 1));
  assign blk_end = (stage_q == SW'(TB_LEN - 1)) || last_q;
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= SCHED_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCHED_IDLE: begin
        if (accept) state_d = SCHED_RUN;
      end
      SCHED_RUN: begin
        if (grp_end) begin
          if (blk_end)     state_d = SCHED_TB_REQ;
          else if (accept) state_d = SCHED_RUN;
          else             state_d = SCHED_IDLE;
        end
      end
      SCHED_TB_REQ: begin
        if (tb_ack) state_d = SCHED_IDLE;
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  always_comb begin
    bmc_en      = (state_q == SCHED_RUN);
    bmc_first   = bmc_en && (group_q == '0);
    bmc_last    = bmc_en && grp_end;
    tb_req      = (state_q == SCHED_TB_REQ);
    // Ready only in IDLE or on a stage-end cycle that does not close a block.
    in_ready    = !rst && ((state_q == SCHED_IDLE) || (bmc_last && !blk_end));
    bmc_group   = group_q;
    bmc_rx_pair = pair_q;
    pm_bank     = bank_q;
    stage_cnt   = stage_q;
    tb_depth    = depth_q;
    tb_final    = final_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      group_q <= '0;
      stage_q <= '0;
      bank_q  <= 1'b0;
      pair_q  <= 2'b00;
      last_q  <= 1'b0;
      depth_q <= '0;
      final_q <= 1'b0;
    end else begin
      if (accept) begin
        pair_q <= in_rx_pair;
        last_q <= in_last;
      end
      // GROUPS is a power of two, so the group counter wraps to 0 by itself.
      if (state_q == SCHED_RUN) group_q <= group_q + GW'(1);
      if (state_q == SCHED_RUN && grp_end) begin
        bank_q <= ~bank_q;
        if (blk_end) begin
          stage_q <= '0;
          depth_q <= (SW + 1)'(stage_q) + (SW + 1)'(1);
          final_q <= last_q;
        end else begin
          stage_q <= stage_q + SW'(1);
        end
      end
      if (state_q == SCHED_TB_REQ && tb_ack && final_q) bank_q <= 1'b0;
    end
  end

endmodule
